controlador_carga_instrucciones: RTL and testbench

CONTROLADOR_CARGA_INSTRUCCIONES -- requirements
Module: controlador_carga_instrucciones

---
 rtl/controlador_carga_instrucciones_if.sv | 33 +++
 rtl/controlador_carga_instrucciones.sv | 118 +++++++++++
 tb/tb_controlador_carga_instrucciones.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/controlador_carga_instrucciones_if.sv
// Command, byte-stream and instruction-memory bus between the loader
// controller and its environment (host link, memory and CPU).
interface controlador_carga_instrucciones_if #(
  parameter int NBITS = 32
);
  logic             i_load;
  logic             i_run;
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic [NBITS-1:0] i_PC;
  logic [NBITS-1:0] i_instruction;
  logic [NBITS-1:0] o_mem_addr;
  logic [NBITS-1:0] o_mem_wdata;
  logic             o_mem_we;
  logic             o_cpu_enable;
  logic             o_busy;
  logic             o_done;
  logic             o_error;

  // Controller side.
  modport slave (
    input  i_load, i_run, i_rx_data, i_rx_valid, i_PC, i_instruction,
    output o_mem_addr, o_mem_wdata, o_mem_we, o_cpu_enable,
           o_busy, o_done, o_error
  );

  // Environment side: host, memory model and CPU.
  modport master (
    output i_load, i_run, i_rx_data, i_rx_valid, i_PC, i_instruction,
    input  o_mem_addr, o_mem_wdata, o_mem_we, o_cpu_enable,
           o_busy, o_done, o_error
  );
endinterface

// File: rtl/controlador_carga_instrucciones.sv
// Program loader: assembles received bytes MSB-first into words, writes them
// to consecutive instruction-memory addresses until the HALT word, then
// gates CPU execution until the CPU fetches HALT.
module controlador_carga_instrucciones #(
  parameter int               NBITS  = 32,
  parameter int               CELDAS = 60,
  parameter logic [NBITS-1:0] HALT   = 32'hFFFF_FFFF
) (
  input logic i_clk,
  input logic i_reset,
  controlador_carga_instrucciones_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    READY,
    RUN,
    DONE,
    ERROR
  } state_t;

  // Highest byte address a word may still be written to.
  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);

  state_t           state_q, state_d;
  logic [NBITS-1:0] ptr_q, ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [NBITS-1:0] buf_q, buf_d;

  // Incoming byte appended at the LSB end, so the first byte ends up on top.
  logic [NBITS-1:0] buf_shifted;
  assign buf_shifted = {buf_q[NBITS-9:0], bus.i_rx_data};

  // State register, write pointer, byte counter and word buffer.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic: download sequencing, overflow detection and run control.
  // NOTE: every signal gets a hold-value default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;

    unique case (state_q)
      IDLE, READY, DONE, ERROR: begin
        if (bus.i_load) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (state_q == READY && bus.i_run) begin
          state_d = RUN;
        end
      end

      LOAD: begin
        if (bus.i_rx_valid) begin
          buf_d = buf_shifted;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // A word that would land past the last cell is never written.
            state_d = (ptr_q > LAST_ADDR) ? ERROR : WRITE;
          end
        end
      end

      WRITE: begin
        ptr_d = ptr_q + NBITS'(4);
        if (buf_q == HALT) begin
          state_d = READY;
        end else begin
          state_d = LOAD;
          // A byte arriving while the previous word is written starts the next word.
          if (bus.i_rx_valid) begin
            buf_d = buf_shifted;
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      RUN: begin
        if (bus.i_instruction == HALT) begin
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state; the address mux lets the CPU
  // own the memory port except during the single write cycle.
  assign bus.o_mem_we     = (state_q == WRITE);
  assign bus.o_mem_addr   = (state_q == WRITE) ? ptr_q : bus.i_PC;
  assign bus.o_mem_wdata  = buf_q;
  assign bus.o_cpu_enable = (state_q == RUN);
  assign bus.o_busy       = (state_q == LOAD) || (state_q == WRITE);
  assign bus.o_done       = (state_q == READY) || (state_q == DONE);
  assign bus.o_error      = (state_q == ERROR);

endmodule

// File: tb/tb_controlador_carga_instrucciones.sv
// Self-checking bench: expected memory writes are queued as words are sent
// and compared when the controller strobes o_mem_we.
module tb_controlador_carga_instrucciones;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;

  controlador_carga_instrucciones_if #(.NBITS(32)) bus ();

  controlador_carga_instrucciones #(
    .NBITS (32),
    .CELDAS(60),
    .HALT  (HALT_W)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];     // {address, data} of each expected write
  logic [31:0] model_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Write monitor: every write strobe must match the oldest queued word.
  always @(negedge clk) begin
    if (rst_n && bus.o_mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", bus.o_mem_addr, 32'hDEAD_BEEF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", bus.o_mem_addr, e[63:32]);
        check("write_data", bus.o_mem_wdata, e[31:0]);
        check("busy_in_write", 32'(bus.o_busy), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    bus.i_load = 1'b1;
    tick();
    bus.i_load = 1'b0;
    model_ptr  = '0;
  endtask

  task automatic pulse_run();
    bus.i_run = 1'b1;
    tick();
    bus.i_run = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends a word MSB-first; queues the expected write unless it must overflow.
  task automatic send_word(input logic [31:0] w, input int gap, input bit expect_write);
    if (expect_write) begin
      exp_q.push_back({model_ptr, w});
      model_ptr = model_ptr + 32'd4;
    end
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic check_flags(input string tag, input logic busy, input logic done,
                             input logic err, input logic cpu_en);
    check({tag, "_busy"},   32'(bus.o_busy),       32'(busy));
    check({tag, "_done"},   32'(bus.o_done),       32'(done));
    check({tag, "_error"},  32'(bus.o_error),      32'(err));
    check({tag, "_cpu_en"}, 32'(bus.o_cpu_enable), 32'(cpu_en));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_load        = 1'b0;
    bus.i_run         = 1'b0;
    bus.i_rx_data     = 8'h00;
    bus.i_rx_valid    = 1'b0;
    bus.i_PC          = 32'h0000_0040;
    bus.i_instruction = 32'h0;
    model_ptr         = '0;
    rst_n             = 1'b0;

    // Reset state.
    repeat (2) tick();
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_we", 32'(bus.o_mem_we), 32'd0);
    check("reset_wdata", bus.o_mem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Commands that must be ignored in IDLE.
    pulse_run();
    check_flags("run_in_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hAB, 0);
    check("idle_rx_ignored_busy", 32'(bus.o_busy), 32'd0);
    check("idle_addr_is_pc", bus.o_mem_addr, 32'h0000_0040);

    // Basic two-word program with gaps between bytes.
    pulse_load();
    check_flags("load_entered", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_run();
    check_flags("run_in_load", 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'h0001_2020, 1, 1'b1);
    send_word(HALT_W, 1, 1'b1);
    check_flags("ready_after_halt", 1'b0, 1'b1, 1'b0, 1'b0);

    // Execution: enable, address tracks PC, load ignored, HALT disables.
    pulse_run();
    check_flags("run_entered", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.i_PC = 32'(i * 4 + 8);
      #1;
      check("run_addr_is_pc", bus.o_mem_addr, 32'(i * 4 + 8));
      tick();
    end
    pulse_load();
    check_flags("load_in_run", 1'b0, 1'b0, 1'b0, 1'b1);
    bus.i_instruction = HALT_W;
    #1;
    check("halt_fetch_still_enabled", 32'(bus.o_cpu_enable), 32'd1);
    tick();
    bus.i_instruction = 32'h0;
    check_flags("done_after_halt", 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back bytes, including a byte during each WRITE cycle.
    pulse_load();
    send_word(32'hDEAD_BEEF, 0, 1'b1);
    send_word(32'h1234_5678, 0, 1'b1);
    send_word(32'hA5C3_0F96, 0, 1'b1);
    send_word(HALT_W, 0, 1'b1);
    tick();
    check_flags("ready_after_stream", 1'b0, 1'b1, 1'b0, 1'b0);

    // Overflow: 15 words fill addresses 0..56, the 16th must not be written.
    pulse_load();
    for (int i = 0; i < 15; i++)
      send_word(32'h1000_0000 + 32'(i), 0, 1'b1);
    send_word(32'h5555_AAAA, 0, 1'b0);
    check_flags("overflow_error", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("overflow_no_write", 32'(bus.o_mem_we), 32'd0);
    pulse_load();
    check_flags("load_after_error", 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(HALT_W, 1, 1'b1);
    check_flags("one_word_program", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a word, then a fresh download.
    pulse_load();
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    rst_n = 1'b0;
    #2;
    check_flags("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_reset_we", 32'(bus.o_mem_we), 32'd0);
    check("mid_reset_wdata", bus.o_mem_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_flags("after_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_load();
    send_word(32'h1122_3344, 1, 1'b1);
    send_word(HALT_W, 0, 1'b1);
    tick();
    check_flags("ready_after_restart", 1'b0, 1'b1, 1'b0, 1'b0);

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
